audio_axil_frame_writer: RTL

- AXI4-Lite master that pushes captured stereo audio frames into the audio_to_AXI slave register bank.
- Each frame is three single-beat writes: left sample to reg0, right sample to reg1, frame sequence number to reg2.
- Sits between the audio capture front end and the audio_to_AXI S00_AXI port.
- Provides a one-entry holding buffer, an overrun counter and a sticky bus-error flag.

---
 rtl/audio_axil_frame_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_axil_frame_writer.sv
// -----------------------------------------------------------------------------
// audio_axil_frame_writer
//
// AXI4-Lite master that pushes captured stereo audio frames into the
// audio_to_AXI slave register bank. Every frame becomes three single-beat
// writes: left sample -> reg0, right sample -> reg1, frame sequence -> reg2.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   smp_strobe             one-cycle pulse, smp_left/smp_right valid
//   smp_left, smp_right    signed samples, C_SAMPLE_WIDTH bits each
//   err_clr                clears the sticky err flag
//   m_axi_aw*/w*/b*        AXI4-Lite write channels (master side)
//   busy                   engine active or holding buffer occupied
//   err                    sticky, set by any non-OKAY write response
//   overrun_cnt            saturating count of dropped frames
//   frame_cnt              wrapping count of completed frames
// -----------------------------------------------------------------------------
module audio_axil_frame_writer #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_SAMPLE_WIDTH = 24
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              smp_strobe,
  input  logic [C_SAMPLE_WIDTH-1:0]         smp_left,
  input  logic [C_SAMPLE_WIDTH-1:0]         smp_right,
  input  logic                              err_clr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic                              busy,
  output logic                              err,
  output logic [15:0]                       overrun_cnt,
  output logic [31:0]                       frame_cnt
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_SAMPLE_WIDTH;

  localparam logic [AW-1:0] ADDR_REG1 = C_BASE_ADDR + AW'(4);
  localparam logic [AW-1:0] ADDR_REG2 = C_BASE_ADDR + AW'(8);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            pend;
  logic [SW-1:0]   buf_left;
  logic [SW-1:0]   buf_right;
  logic [SW-1:0]   work_right;
  logic [1:0]      idx;

  logic            drain;
  logic            aw_done;
  logic            w_done;
  logic            b_hs;
  logic            last_write;

  // Replicate the sample sign bit across the full bus width.
  function automatic logic [DW-1:0] sign_extend(input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r         = {DW{s[SW-1]}};
    r[SW-1:0] = s;
    return r;
  endfunction

  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = {(DW/8){1'b1}};

  // The buffer is drained in the one IDLE cycle that sees it full, which is
  // also the cycle a new strobe may refill it without counting an overrun.
  assign drain      = (state == IDLE) && pend;
  // A channel counts as done once its valid has already dropped or it is
  // handshaking this cycle; AW and W can finish in either order.
  assign aw_done    = !m_axi_awvalid || m_axi_awready;
  assign w_done     = !m_axi_wvalid  || m_axi_wready;
  assign b_hs       = m_axi_bvalid && m_axi_bready;
  assign last_write = (idx == 2'd2);

  assign busy = (state != IDLE) || pend;

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pend) state_next = ADDR;
      ADDR: if (aw_done && w_done) state_next = RESP;
      RESP: if (b_hs) state_next = last_write ? IDLE : ADDR;
      default: state_next = IDLE;
    endcase
  end

  // One-entry holding buffer and the saturating overrun counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend        <= 1'b0;
      buf_left    <= '0;
      buf_right   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (smp_strobe && (!pend || drain)) begin
        pend      <= 1'b1;
        buf_left  <= smp_left;
        buf_right <= smp_right;
      end else if (drain) begin
        pend <= 1'b0;
      end
      if (smp_strobe && pend && !drain && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end

  // Write channel registers: address/data are loaded only when a new write
  // is launched, so they stay stable while the corresponding valid is high.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      work_right    <= '0;
      idx           <= 2'd0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            work_right    <= buf_right;
            idx           <= 2'd0;
            m_axi_awaddr  <= C_BASE_ADDR;
            m_axi_wdata   <= sign_extend(buf_left);
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end
        end
        ADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done)              m_axi_bready  <= 1'b1;
        end
        RESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            if (last_write) begin
              frame_cnt <= frame_cnt + 32'd1;
            end else begin
              idx           <= idx + 2'd1;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              if (idx == 2'd0) begin
                m_axi_awaddr <= ADDR_REG1;
                m_axi_wdata  <= sign_extend(work_right);
              end else begin
                // reg2 carries the count before this frame completes.
                m_axi_awaddr <= ADDR_REG2;
                m_axi_wdata  <= DW'(frame_cnt);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err <= 1'b0;
    end else if (b_hs && (m_axi_bresp != 2'b00)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
